// File: rtl/aoi_pkg.sv
// Shared definitions for the four-input AOI self-test sweep: FSM encoding,
// vector count and result widths.
package aoi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int          NUM_VECTORS = 16;
  localparam logic [3:0]  LAST_IDX    = 4'd15;
  localparam int          ERR_W       = 5;

endpackage : aoi_pkg

// File: rtl/aoi_ref_model.sv
// Golden model of the AOI gate: e = a&b, f = c&d, g = NOR(e, f).
// Purely combinational; also usable as a scoreboard in benches.
module aoi_ref_model (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic exp_e,
  output logic exp_f,
  output logic exp_g
);

  assign exp_e = a & b;
  assign exp_f = c & d;
  assign exp_g = ~(exp_e | exp_f);

endmodule : aoi_ref_model

// File: rtl/aoi_sweep_ctrl.sv
// Self-test sequencer: walks all 16 {a,b,c,d} vectors through an external AOI
// gate, samples e/f/g after a settle time and accumulates mismatch results.
module aoi_sweep_ctrl
  import aoi_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             e,
  input  logic             f,
  input  logic             g,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       first_fail_vec,
  output logic             first_fail_valid
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t           r_state;
  logic [3:0]       r_idx;
  logic [3:0]       r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic [3:0]       r_ffv;
  logic             r_ffvalid;

  logic             w_exp_e;
  logic             w_exp_f;
  logic             w_exp_g;
  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_next;

  // The vector index doubles as the registered gate stimulus {a,b,c,d}.
  aoi_ref_model u_ref (
    .a     (r_idx[3]),
    .b     (r_idx[2]),
    .c     (r_idx[1]),
    .d     (r_idx[0]),
    .exp_e (w_exp_e),
    .exp_f (w_exp_f),
    .exp_g (w_exp_g)
  );

  assign w_mismatch = (e != w_exp_e) | (f != w_exp_f) | (g != w_exp_g);
  assign w_err_next = r_err + ERR_W'(w_mismatch);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; pass is derived from w_err_next to include the last vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= 4'd0;
      r_cnt     <= 4'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= '0;
      r_ffv     <= 4'd0;
      r_ffvalid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_idx     <= 4'd0;
            r_cnt     <= 4'd0;
            r_err     <= '0;
            r_ffvalid <= 1'b0;
            r_pass    <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_cnt   <= 4'd0;
            r_state <= ST_CHECK;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_CHECK: begin
          r_err <= w_err_next;
          if (w_mismatch && !r_ffvalid) begin
            r_ffv     <= r_idx;
            r_ffvalid <= 1'b1;
          end
          if (r_idx == LAST_IDX) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_pass  <= (w_err_next == '0);
            r_state <= ST_DONE;
          end else begin
            r_idx   <= r_idx + 4'd1;
            r_cnt   <= 4'd0;
            r_state <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign {a, b, c, d}     = r_idx;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err;
  assign first_fail_vec   = r_ffv;
  assign first_fail_valid = r_ffvalid;

endmodule : aoi_sweep_ctrl

// File: doc/aoi_sweep_ctrl.md
Name: aoi_sweep_ctrl

Overview:
Self-test sequencer for the four_input_aoi_gate_a datapath.
- On a start pulse it drives all 16 {a,b,c,d} combinations into an external gate instance.
- For each vector it waits a programmable settle time, then samples e, f, g and compares them against a golden model.
- It reports an error count, the first failing vector and a pass flag.
- It sits beside the gate instance in board-level and bench top levels and replaces free-running toggle stimulus.

Parameters:
SETTLE_CYCLES, 2, clocks that each vector is held before sampling; legal range 1..15.
NUM_VECTORS, 16, vectors per sweep; fixed at 16 (4 inputs); not overridable.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin sweep; sampled only in IDLE
e  input  1  gate output e (AND of a,b)
f  input  1  gate output f (AND of c,d)
g  input  1  gate output g (NOR of e,f)
a  output  1  gate input a (vector bit 3)
b  output  1  gate input b (vector bit 2)
c  output  1  gate input c (vector bit 1)
d  output  1  gate input d (vector bit 0)
busy  output  1  sweep in progress
done  output  1  one-cycle pulse at sweep end
pass  output  1  last sweep had zero mismatches
err_count  output  5  mismatching vectors in last or current sweep (0..16)
first_fail_vec  output  4  {a,b,c,d} of first mismatch
first_fail_valid  output  1  first_fail_vec holds a captured value

Behaviour:
- Reset values: a=b=c=d=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0, state=IDLE, idx=0, settle counter=0.
- Golden model: exp_e = a&b; exp_f = c&d; exp_g = ~(exp_e|exp_f). Computed from the registered a..d outputs.
- A vector mismatches if any of e, f, g differs from expected. Each vector counts at most 1.
- States: IDLE, SETTLE, CHECK, DONE. All outputs are registered.
- IDLE:
  - On start=1 at an edge: load idx=0 and {a,b,c,d}=4'b0000.
  - Clear err_count, first_fail_valid and pass; set busy=1; go to SETTLE with counter=0.
- SETTLE:
  - Counter increments each cycle.
  - When counter==SETTLE_CYCLES-1, go to CHECK.
  - Vector is held for exactly SETTLE_CYCLES cycles.
- CHECK (one cycle):
  - e, f, g are sampled at the edge leaving CHECK.
  - On mismatch: err_count+1. If first_fail_valid=0, capture first_fail_vec=idx and set first_fail_valid=1.
  - If idx<15: idx+1, load {a,b,c,d}=idx+1, go to SETTLE.
  - If idx==15: go to DONE.
- DONE (one cycle):
  - done=1, busy=0, pass = (final err_count==0). The pass value includes the last vector's result.
  - Go to IDLE. a..d hold vector 4'b1111 until the next start.
- Latency: each vector takes SETTLE_CYCLES+1 cycles. done is high in the cycle after edge 16*(SETTLE_CYCLES+1), counting the start-accept edge as edge 0. With the default this is edge 48.
- Boundary conditions:
  - start while busy or in DONE: ignored, no restart.
  - start held high continuously: a new sweep begins at the first IDLE edge after DONE.
  - rst mid-sweep: immediate return to reset values at that edge; no done pulse. Partial err_count is discarded.
  - Results (err_count, first_fail_*, pass) persist in IDLE until the next accepted start.
  - err_count reaches at most 16 and never wraps.
  - idx wraps are unreachable: the transition at idx==15 goes to DONE.

Decomposition:
- Shared package/include aoi_pkg:
  - state encodings (IDLE=2'd0, SETTLE=2'd1, CHECK=2'd2, DONE=2'd3)
  - NUM_VECTORS=16, LAST_IDX=4'd15, ERR_W=5
- One sub-module: aoi_ref_model. Purely combinational golden model (a,b,c,d -> exp_e, exp_f, exp_g). Reused by benches as the scoreboard.

Test Plan:
- Correct gate connected, SETTLE_CYCLES=2, start pulse at edge 0 -> {a,b,c,d} steps 0000..1111, each held 3 cycles; done pulse after edge 48; pass=1; err_count=0; first_fail_valid=0.
- Bench gate model with g stuck at 0 -> err_count=9, first_fail_vec=4'b0000, first_fail_valid=1, pass=0.
- Bench model with e stuck at 1 -> err_count=12 (all vectors with a&b=0), first_fail_vec=4'b0000, pass=0.
- Bench model with f wrong only for vector 4'b0111 (f forced 0) -> err_count=1, first_fail_vec=4'b0111.
- rst asserted at edge 20 mid-sweep, then start reissued -> all outputs at reset values after edge 20, no done pulse; second sweep completes normally with pass=1.
- start pulsed again at edge 10 while busy, and start held high through DONE -> first sweep unaffected; a second sweep begins at the first IDLE edge after DONE and busy re-asserts.
